// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - VGA timing stream bundle between the timing generator and the draw stages.
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport out  (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport sink (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA pixel/line counters with registered, zero-skew sync and blank flags.
module vga_timing_gen #(
    parameter int HACTIVE = 800,
    parameter int HFP     = 40,
    parameter int HSW     = 128,
    parameter int HTOTAL  = 1056,
    parameter int VACTIVE = 600,
    parameter int VFP     = 1,
    parameter int VSW     = 4,
    parameter int VTOTAL  = 628
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    vga_if.out    out,
    output logic  frame_start
);

    if (!((HACTIVE + HFP + HSW < HTOTAL) && (HTOTAL <= 2048))) begin : g_bad_h
        $error("vga_timing_gen: horizontal timing parameters out of range");
    end
    if (!((VACTIVE + VFP + VSW < VTOTAL) && (VTOTAL <= 2048))) begin : g_bad_v
        $error("vga_timing_gen: vertical timing parameters out of range");
    end

    localparam logic [10:0] H_LAST   = 11'(HTOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(VTOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(HACTIVE);
    localparam logic [10:0] V_ACT    = 11'(VACTIVE);
    localparam logic [10:0] HS_START = 11'(HACTIVE + HFP);
    localparam logic [10:0] HS_END   = 11'(HACTIVE + HFP + HSW);
    localparam logic [10:0] VS_START = 11'(VACTIVE + VFP);
    localparam logic [10:0] VS_END   = 11'(VACTIVE + VFP + VSW);

    logic [10:0] hcount_q, hcount_d;
    logic [10:0] vcount_q, vcount_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        hblnk_q, hblnk_d;
    logic        vblnk_q, vblnk_d;
    logic        frame_start_q, frame_start_d;

    always_comb begin
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        frame_start_d = 1'b0;
        if (en) begin
            if (hcount_q == H_LAST) begin
                hcount_d = 11'd0;
                if (vcount_q == V_LAST) begin
                    vcount_d      = 11'd0;
                    frame_start_d = 1'b1;
                end else begin
                    vcount_d = vcount_q + 11'd1;
                end
            end else begin
                hcount_d = hcount_q + 11'd1;
            end
        end
        // Flags decode the next counts so they line up with the counts they accompany.
        hblnk_d = (hcount_d >= H_ACT);
        hsync_d = (hcount_d >= HS_START) && (hcount_d < HS_END);
        vblnk_d = (vcount_d >= V_ACT);
        vsync_d = (vcount_d >= VS_START) && (vcount_d < VS_END);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcount_q      <= 11'd0;
            vcount_q      <= 11'd0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            hblnk_q       <= 1'b0;
            vblnk_q       <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            hblnk_q       <= hblnk_d;
            vblnk_q       <= vblnk_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign out.hcount  = hcount_q;
    assign out.vcount  = vcount_q;
    assign out.hsync   = hsync_q;
    assign out.vsync   = vsync_q;
    assign out.hblnk   = hblnk_q;
    assign out.vblnk   = vblnk_q;
    assign out.rgb     = 12'h000;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - Directed checks of vga_timing_gen at default, 640x480 and tiny timings.
module tb_vga_timing_gen;

    logic clk;
    logic rst;
    logic en_a, en_b, en_c;
    logic fs_a, fs_b, fs_c;

    vga_if vif_a ();
    vga_if vif_b ();
    vga_if vif_c ();

    vga_timing_gen u_a (
        .clk(clk), .rst(rst), .en(en_a), .out(vif_a), .frame_start(fs_a)
    );

    vga_timing_gen #(
        .HACTIVE(640), .HFP(16), .HSW(96), .HTOTAL(800),
        .VACTIVE(480), .VFP(10), .VSW(2), .VTOTAL(525)
    ) u_b (
        .clk(clk), .rst(rst), .en(en_b), .out(vif_b), .frame_start(fs_b)
    );

    vga_timing_gen #(
        .HACTIVE(8), .HFP(2), .HSW(3), .HTOTAL(16),
        .VACTIVE(4), .VFP(1), .VSW(2), .VTOTAL(9)
    ) u_c (
        .clk(clk), .rst(rst), .en(en_c), .out(vif_c), .frame_start(fs_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    int ha = 0, va = 0, fa = 0;
    int hb = 0, vb = 0, fb = 0;
    int hc = 0, vc = 0, fc = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic adv(inout int h, inout int v, inout int f,
                       input int ht, input int vt, input logic e);
        if (rst) begin
            h = 0; v = 0; f = 0;
        end else if (e) begin
            f = (h == ht - 1 && v == vt - 1) ? 1 : 0;
            if (h == ht - 1) begin
                h = 0;
                v = (v == vt - 1) ? 0 : v + 1;
            end else begin
                h = h + 1;
            end
        end else begin
            f = 0;
        end
    endtask

    function automatic logic [63:0] expv(int h, int v, int f, int hact, int hfp, int hsw,
                                         int vact, int vfp, int vsw);
        logic hs, vs, hbk, vbk;
        hbk = (h >= hact);
        hs  = (h >= hact + hfp) && (h < hact + hfp + hsw);
        vbk = (v >= vact);
        vs  = (v >= vact + vfp) && (v < vact + vfp + vsw);
        return {26'd0, h[10:0], v[10:0], hs, vs, hbk, vbk, 12'h000, f[0]};
    endfunction

    function automatic logic [63:0] pack(logic [10:0] h, logic [10:0] v, logic hs, logic vs,
                                         logic hbk, logic vbk, logic [11:0] rgb, logic f);
        return {26'd0, h, v, hs, vs, hbk, vbk, rgb, f};
    endfunction

    task automatic sb();
        check("sb_a", pack(vif_a.hcount, vif_a.vcount, vif_a.hsync, vif_a.vsync,
                           vif_a.hblnk, vif_a.vblnk, vif_a.rgb, fs_a),
              expv(ha, va, fa, 800, 40, 128, 600, 1, 4));
        check("sb_b", pack(vif_b.hcount, vif_b.vcount, vif_b.hsync, vif_b.vsync,
                           vif_b.hblnk, vif_b.vblnk, vif_b.rgb, fs_b),
              expv(hb, vb, fb, 640, 16, 96, 480, 10, 2));
        check("sb_c", pack(vif_c.hcount, vif_c.vcount, vif_c.hsync, vif_c.vsync,
                           vif_c.hblnk, vif_c.vblnk, vif_c.rgb, fs_c),
              expv(hc, vc, fc, 8, 2, 3, 4, 1, 2));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        adv(ha, va, fa, 1056, 628, en_a);
        adv(hb, vb, fb, 800, 525, en_b);
        adv(hc, vc, fc, 16, 9, en_c);
        sb();
    endtask

    initial begin
        int hs_cnt, fa_cnt, fc_cnt, fc_first, vs_c_cnt, vb_c_cnt;
        int hb_rise, hs_rise;
        logic hb_prev, hs_prev;

        rst  = 1'b1;
        en_a = 1'b0;
        en_b = 1'b0;
        en_c = 1'b0;
        repeat (3) step();
        check("rst_hcount", 64'(vif_a.hcount), 64'd0);
        check("rst_hsync", 64'(vif_a.hsync), 64'd0);

        @(negedge clk);
        rst  = 1'b0;
        en_a = 1'b1;
        en_b = 1'b1;
        en_c = 1'b1;
        step();
        check("first_hcount", 64'(vif_a.hcount), 64'd1);
        check("first_fs", 64'(fs_a), 64'd0);

        hs_cnt = 0; fa_cnt = 0; fc_cnt = 0; fc_first = -1;
        vs_c_cnt = 0; vb_c_cnt = 0; hb_rise = -1; hs_rise = -1;
        hb_prev = vif_a.hblnk;
        hs_prev = vif_a.hsync;
        for (int k = 2; k <= 2113; k++) begin
            step();
            if (vif_a.hsync) hs_cnt++;
            if (vif_a.hblnk && !hb_prev && hb_rise < 0) hb_rise = int'(vif_a.hcount);
            if (vif_a.hsync && !hs_prev && hs_rise < 0) hs_rise = int'(vif_a.hcount);
            hb_prev = vif_a.hblnk;
            hs_prev = vif_a.hsync;
            if (fs_a) fa_cnt++;
            if (fs_c) begin
                fc_cnt++;
                if (fc_first < 0) fc_first = k;
            end
            if (k <= 144 && vif_c.vsync) vs_c_cnt++;
            if (k <= 144 && vif_c.vblnk) vb_c_cnt++;
            if (k == 1055) check("line_end", 64'({vif_a.hcount, vif_a.vcount}), 64'({11'd1055, 11'd0}));
            if (k == 1056) check("line_wrap", 64'({vif_a.hcount, vif_a.vcount}), 64'({11'd0, 11'd1}));
            if (k == 800)  check("b_line1", 64'({vif_b.hcount, vif_b.vcount}), 64'({11'd0, 11'd1}));
            if (k == 1600) check("b_line2", 64'({vif_b.hcount, vif_b.vcount}), 64'({11'd0, 11'd2}));
        end
        check("hsync_cycles", 64'(hs_cnt), 64'd256);
        check("hblnk_rise", 64'(hb_rise), 64'd800);
        check("hsync_rise", 64'(hs_rise), 64'd840);
        check("a_no_fs", 64'(fa_cnt), 64'd0);
        check("c_fs_count", 64'(fc_cnt), 64'd14);
        check("c_fs_first", 64'(fc_first), 64'd144);
        check("c_vsync_cycles", 64'(vs_c_cnt), 64'd32);
        check("c_vblnk_cycles", 64'(vb_c_cnt), 64'd80);

        // A now sits at (1,2); walk to hcount 839 just before the hsync window.
        repeat (838) step();
        check("pre_freeze", 64'({vif_a.hcount, vif_a.vcount, vif_a.hsync}), 64'({11'd839, 11'd2, 1'b0}));
        en_a = 1'b0;
        repeat (10) step();
        check("frozen", 64'({vif_a.hcount, vif_a.vcount, vif_a.hsync, fs_a}),
              64'({11'd839, 11'd2, 1'b0, 1'b0}));
        en_a = 1'b1;
        step();
        check("resume", 64'({vif_a.hcount, vif_a.hsync}), 64'({11'd840, 1'b1}));

        repeat (60) step();
        check("pre_rst", 64'({vif_a.hcount, vif_a.hsync, vif_a.hblnk}), 64'({11'd900, 1'b1, 1'b1}));

        @(negedge clk);
        rst = 1'b1;
        #1;
        ha = 0; va = 0; fa = 0;
        hb = 0; vb = 0; fb = 0;
        hc = 0; vc = 0; fc = 0;
        sb();
        check("async_rst", 64'({vif_a.hcount, vif_a.vcount, vif_a.hsync, vif_a.hblnk, fs_a}), 64'd0);
        step();

        @(negedge clk);
        rst = 1'b0;
        step();
        check("restart", 64'({vif_a.hcount, vif_a.vcount, fs_a, fs_c}), 64'({11'd1, 11'd0, 1'b0, 1'b0}));

        fc_cnt = 0; fc_first = -1;
        for (int k = 2; k <= 300; k++) begin
            step();
            if (fs_c) begin
                fc_cnt++;
                if (fc_first < 0) fc_first = k;
            end
        end
        check("c_fs_after_rst", 64'(fc_cnt), 64'd2);
        check("c_fs_first_rst", 64'(fc_first), 64'd144);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
